// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    SUM  = 2'd3
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver. Bit timing uses a down-counter reloaded at each bit and
// compared against zero; sampling happens mid-bit.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sampling 8 data bits, LSB first
// RX_STOP  | sampling stop bit; high -> byte valid, low -> framing error
module uart_rx_8n1
  import imem_loader_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLK_DIV - 1);

  rx_state_t        rx_state, rx_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             tc;
  logic             fall;

  assign tc   = (cnt == '0);
  // A fall needs a preceding high, so after a framing error the line must
  // return high before the receiver can start again.
  assign fall = rx_prev & ~rx_sync;

  // Two-flop synchronizer plus previous-value flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next-state decode
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (fall) rx_next = RX_START;
      RX_START: if (tc) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tc && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tc) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and one-cycle result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= HALF_TC;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt     <= HALF_TC;
          bit_idx <= 3'd0;
        end
        RX_START: cnt <= tc ? FULL_TC : cnt - 1'b1;
        RX_DATA: begin
          if (tc) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            cnt     <= FULL_TC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (tc) begin
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: cnt <= HALF_TC;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Serial program loader: parses A5/len/data/sum frames from the UART and
// writes instruction bytes into imem, holding the CPU until a verified load.
//
// state | meaning
// IDLE  | waiting for header byte; other bytes ignored
// LEN   | expecting length byte N (1..IMEM_DEPTH)
// DATA  | writing N instruction bytes, accumulating the sum
// SUM   | comparing checksum byte; release CPU on match
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLK_DIV    = 16,
  parameter int         IMEM_DEPTH = 16,
  parameter int         ADDR_W     = 4,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);
  localparam logic [7:0]      MAX_LEN = 8'(IMEM_DEPTH);

  ld_state_t       state, state_next;
  logic            rx_valid, rx_ferr;
  logic [7:0]      rx_byte;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] idx;
  logic [7:0]      sum;
  logic            is_hdr, len_bad, last_data, sum_ok;

  uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  // Loader state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Loader next-state decode; a framing error outside IDLE aborts the frame
  always_comb begin
    state_next = state;
    if (rx_ferr && state != IDLE) begin
      state_next = IDLE;
    end else if (rx_valid) begin
      case (state)
        IDLE:    if (is_hdr) state_next = LEN;
        LEN:     state_next = len_bad ? IDLE : DATA;
        DATA:    if (last_data) state_next = SUM;
        SUM:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output-side decode of the received byte against the current frame
  always_comb begin
    busy      = (state != IDLE);
    is_hdr    = (rx_byte == HDR_BYTE);
    len_bad   = (rx_byte == 8'h00) || (rx_byte > MAX_LEN);
    last_data = ((idx + ONE) == count);
    sum_ok    = (rx_byte == sum);
  end

  // Frame datapath: write port, running sum, hold/done/error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 8'h00;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      count      <= '0;
      idx        <= '0;
      sum        <= 8'h00;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      if (rx_ferr && state != IDLE) begin
        load_err <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (is_hdr) begin
              cpu_hold <= 1'b1;
              load_err <= 1'b0;
              sum      <= 8'h00;
            end
          end
          LEN: begin
            if (len_bad) begin
              load_err <= 1'b1;
            end else begin
              count      <= rx_byte[ADDR_W:0];
              idx        <= '0;
              imem_waddr <= '0;
            end
          end
          DATA: begin
            // imem_waddr holds the last written address, so it stops at
            // N-1 instead of wrapping after a full-depth load.
            imem_we    <= 1'b1;
            imem_wdata <= rx_byte;
            imem_waddr <= idx[ADDR_W-1:0];
            idx        <= idx + ONE;
            sum        <= sum + rx_byte;
          end
          SUM: begin
            if (sum_ok) begin
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for the UART program loader.
module tb_imem_uart_loader;
  localparam int CD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       imem_we;
  logic [3:0] imem_waddr;
  logic [7:0] imem_wdata;
  logic       cpu_hold, busy, load_done, load_err;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  int rxv_count = 0;
  int w0, d0, r0;
  logic [7:0] mem [16];
  logic [7:0] gold [9];
  logic [7:0] big [16];
  logic [7:0] big_sum;
  logic [7:0] txq [$];

  imem_uart_loader #(.CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_count++;
      mem[imem_waddr] = imem_wdata;
    end
    if (load_done) done_count++;
    if (dut.u_rx.rx_valid) rxv_count++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CD) @(negedge clk);
    end
    rx = stop;
    repeat (CD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CD) @(negedge clk);
  endtask

  task automatic send_q();
    while (txq.size() > 0) send_byte(txq.pop_front(), 1'b1);
  endtask

  task automatic send_golden(input logic [7:0] sum_byte);
    txq.push_back(8'hA5);
    txq.push_back(8'h09);
    for (int i = 0; i < 9; i++) txq.push_back(gold[i]);
    txq.push_back(sum_byte);
    send_q();
  endtask

  task automatic chk_gold_mem(input string tag);
    for (int i = 0; i < 9; i++) chk(tag, {24'h0, mem[i]}, {24'h0, gold[i]});
  endtask

  initial begin
    gold[0] = 8'h8A; gold[1] = 8'h90; gold[2] = 8'hA0; gold[3] = 8'hB1;
    gold[4] = 8'h17; gold[5] = 8'h29; gold[6] = 8'hD1; gold[7] = 8'h40;
    gold[8] = 8'hE3;
    big_sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      big[i]  = 8'(i * 13 + 7);
      big_sum = big_sum + big[i];
    end

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_we",    {31'h0, imem_we},   0);
    chk("rst_waddr", {28'h0, imem_waddr}, 0);
    chk("rst_wdata", {24'h0, imem_wdata}, 0);
    chk("rst_hold",  {31'h0, cpu_hold},  1);
    chk("rst_busy",  {31'h0, busy},      0);
    chk("rst_done",  {31'h0, load_done}, 0);
    chk("rst_err",   {31'h0, load_err},  0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Golden load
    w0 = wr_count; d0 = done_count;
    send_byte(8'hA5, 1'b1);
    chk("gold_busy_hdr", {31'h0, busy}, 1);
    chk("gold_hold_hdr", {31'h0, cpu_hold}, 1);
    send_byte(8'h09, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(gold[i], 1'b1);
    send_byte(8'h9F, 1'b1);
    chk("gold_writes", wr_count - w0, 9);
    chk_gold_mem("gold_mem");
    chk("gold_waddr", {28'h0, imem_waddr}, 8);
    chk("gold_done",  done_count - d0, 1);
    chk("gold_hold",  {31'h0, cpu_hold}, 0);
    chk("gold_err",   {31'h0, load_err}, 0);
    chk("gold_busy",  {31'h0, busy}, 0);

    // Bad checksum then corrected resend
    w0 = wr_count; d0 = done_count;
    send_golden(8'h9E);
    chk("bad_writes", wr_count - w0, 9);
    chk("bad_err",    {31'h0, load_err}, 1);
    chk("bad_hold",   {31'h0, cpu_hold}, 1);
    chk("bad_done",   done_count - d0, 0);
    send_byte(8'hA5, 1'b1);
    chk("resend_err_clr", {31'h0, load_err}, 0);
    chk("resend_hold",    {31'h0, cpu_hold}, 1);
    send_byte(8'h09, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(gold[i], 1'b1);
    send_byte(8'h9F, 1'b1);
    chk("resend_hold_rel", {31'h0, cpu_hold}, 0);
    chk("resend_done",     done_count - d0, 1);

    // Length bounds
    w0 = wr_count;
    txq.push_back(8'hA5); txq.push_back(8'h00); send_q();
    chk("len0_err",  {31'h0, load_err}, 1);
    chk("len0_busy", {31'h0, busy}, 0);
    chk("len0_hold", {31'h0, cpu_hold}, 1);
    txq.push_back(8'hA5); txq.push_back(8'h11); send_q();
    chk("len17_err",  {31'h0, load_err}, 1);
    chk("len17_busy", {31'h0, busy}, 0);
    chk("len_writes", wr_count - w0, 0);
    w0 = wr_count; d0 = done_count;
    txq.push_back(8'hA5); txq.push_back(8'h10);
    for (int i = 0; i < 16; i++) txq.push_back(big[i]);
    txq.push_back(big_sum);
    send_q();
    chk("len16_writes", wr_count - w0, 16);
    chk("len16_waddr",  {28'h0, imem_waddr}, 15);
    chk("len16_mem0",   {24'h0, mem[0]},  {24'h0, big[0]});
    chk("len16_mem15",  {24'h0, mem[15]}, {24'h0, big[15]});
    chk("len16_done",   done_count - d0, 1);
    chk("len16_hold",   {31'h0, cpu_hold}, 0);
    chk("len16_err",    {31'h0, load_err}, 0);

    // Line noise: short glitch, then garbage bytes before a header
    r0 = rxv_count;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CD) @(negedge clk);
    chk("glitch_rxv",  rxv_count - r0, 0);
    chk("glitch_busy", {31'h0, busy}, 0);
    w0 = wr_count; d0 = done_count; r0 = rxv_count;
    txq.push_back(8'h00); txq.push_back(8'hFF); txq.push_back(8'h3C); send_q();
    chk("garbage_rxv",  rxv_count - r0, 3);
    chk("garbage_busy", {31'h0, busy}, 0);
    chk("garbage_hold", {31'h0, cpu_hold}, 0);
    send_golden(8'h9F);
    chk("noise_writes", wr_count - w0, 9);
    chk("noise_done",   done_count - d0, 1);
    chk("noise_hold",   {31'h0, cpu_hold}, 0);

    // Framing error on the third data byte
    w0 = wr_count; d0 = done_count;
    txq.push_back(8'hA5); txq.push_back(8'h09);
    txq.push_back(8'h8A); txq.push_back(8'h90);
    send_q();
    send_byte(8'hA0, 1'b0);
    chk("ferr_err",    {31'h0, load_err}, 1);
    chk("ferr_busy",   {31'h0, busy}, 0);
    chk("ferr_writes", wr_count - w0, 2);
    chk("ferr_hold",   {31'h0, cpu_hold}, 1);
    w0 = wr_count;
    send_golden(8'h9F);
    chk("ferr_rec_writes", wr_count - w0, 9);
    chk("ferr_rec_done",   done_count - d0, 1);
    chk("ferr_rec_hold",   {31'h0, cpu_hold}, 0);
    chk("ferr_rec_err",    {31'h0, load_err}, 0);

    // Reset mid-frame
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    txq.push_back(8'hA5); txq.push_back(8'h09);
    for (int i = 0; i < 4; i++) txq.push_back(gold[i]);
    send_q();
    chk("mid_busy", {31'h0, busy}, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_we",    {31'h0, imem_we}, 0);
    chk("mid_waddr", {28'h0, imem_waddr}, 0);
    chk("mid_wdata", {24'h0, imem_wdata}, 0);
    chk("mid_hold",  {31'h0, cpu_hold}, 1);
    chk("mid_busy0", {31'h0, busy}, 0);
    chk("mid_err",   {31'h0, load_err}, 0);
    w0 = wr_count; d0 = done_count;
    send_golden(8'h9F);
    chk("mid_rec_writes", wr_count - w0, 9);
    chk_gold_mem("mid_rec_mem");
    chk("mid_rec_done", done_count - d0, 1);
    chk("mid_rec_hold", {31'h0, cpu_hold}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
